// File: rtl/button_click_decoder_if.sv
// Edge-pulse inputs and gesture-event outputs between the button front end and the click decoder.
// The front end drives the master side; the decoder implements the slave side.
interface button_click_decoder_if;
  logic i_rise;
  logic i_fall;
  logic o_single;
  logic o_double;
  logic o_long;
  logic o_pressed;

  modport master (
    output i_rise, i_fall,
    input  o_single, o_double, o_long, o_pressed
  );

  modport slave (
    input  i_rise, i_fall,
    output o_single, o_double, o_long, o_pressed
  );
endinterface

// File: rtl/button_click_decoder.sv
// Classifies debounced press/release pulses into single click, double click and long press events.
// Time is measured in ms from a free-running tick; every output is registered.
module button_click_decoder #(
  parameter int TICK_DIV  = 100_000,
  parameter int LONG_MS   = 1000,
  parameter int DOUBLE_MS = 300
) (
  input logic                   clk,
  input logic                   reset,
  button_click_decoder_if.slave bus
);

  localparam int MAX_MS = (LONG_MS > DOUBLE_MS) ? LONG_MS : DOUBLE_MS;
  localparam int MS_W   = $clog2(MAX_MS + 1);
  localparam int TICK_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HOLD,
    GAP,
    PRESS2
  } state_t;

  state_t            state, next_state;
  logic [TICK_W-1:0] tick_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic              tick;
  logic              rise, fall;
  logic              long_hit, double_hit;
  logic              single_d, double_d, long_d, pressed_d;

  // Simultaneous press and release pulses carry no usable information, so both are dropped.
  assign rise = bus.i_rise & ~bus.i_fall;
  assign fall = bus.i_fall & ~bus.i_rise;

  assign tick       = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign long_hit   = tick && (ms_cnt == MS_W'(LONG_MS - 1));
  assign double_hit = tick && (ms_cnt == MS_W'(DOUBLE_MS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (rise) next_state = PRESS1;
      PRESS1:    if (fall) next_state = GAP;
                 else if (long_hit) next_state = LONG_HOLD;
      LONG_HOLD: if (fall) next_state = IDLE;
      GAP:       if (rise) next_state = PRESS2;
                 else if (double_hit) next_state = IDLE;
      PRESS2:    if (fall) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Edge pulses take priority over a coincident threshold tick.
  always_comb begin
    single_d  = (state == GAP) && !rise && double_hit;
    double_d  = (state == PRESS2) && fall;
    long_d    = (state == PRESS1) && !fall && long_hit;
    pressed_d = (next_state == PRESS1) || (next_state == LONG_HOLD) || (next_state == PRESS2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_cnt <= '0;
    end else if (next_state != state) begin
      ms_cnt <= '0;
    end else if (tick && (state == PRESS1 || state == GAP) && ms_cnt != MS_W'(MAX_MS)) begin
      ms_cnt <= ms_cnt + MS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.o_single  <= 1'b0;
      bus.o_double  <= 1'b0;
      bus.o_long    <= 1'b0;
      bus.o_pressed <= 1'b0;
    end else begin
      bus.o_single  <= single_d;
      bus.o_double  <= double_d;
      bus.o_long    <= long_d;
      bus.o_pressed <= pressed_d;
    end
  end

endmodule
